// File: rtl/seq_divider_32_pkg.sv
// Shared definitions for the sequential divider: default sizes, FSM state
// encoding and the lookahead carry helper used by the trial subtractor.
package seq_divider_32_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = 6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    // Carry into bit position k (0..4) of a 4-bit lookahead group, written as
    // the flat sum-of-products: some lower bit j generates and every bit
    // between j and k propagates, or the group carry-in propagates all the way.
    function automatic logic cla4_carry(input logic [3:0] g,
                                        input logic [3:0] p,
                                        input logic       c0,
                                        input int         k);
        logic c;
        logic term;
        c = 1'b0;
        for (int j = 0; j < 4; j++) begin
            if (j < k) begin
                term = g[j];
                for (int m = j + 1; m < 4; m++) begin
                    if (m < k) begin
                        term = term & p[m];
                    end
                end
                c = c | term;
            end
        end
        term = c0;
        for (int m = 0; m < 4; m++) begin
            if (m < k) begin
                term = term & p[m];
            end
        end
        c = c | term;
        return c;
    endfunction

endpackage

// File: rtl/seq_divider_32_sub_step.sv
// Trial subtractor for one restoring-division step: a - b computed as
// a + ~b + 1 over WIDTH+1 bits. The operand is padded up to whole 16-bit
// slices, each slice being four 4-bit lookahead groups chained by group carry.
// Pad bits have a=0, ~b=1, so they only propagate the carry out of the top
// real bit; the final carry therefore equals the carry out of bit WIDTH.
module sub_step_32
    import seq_divider_32_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH:0]   a,
    input  logic [WIDTH:0]   b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int NBITS  = WIDTH + 1;
    localparam int NSLICE = (NBITS + 15) / 16;
    localparam int PW     = NSLICE * 16;
    localparam int NG     = PW / 4;

    logic [PW-1:0] a_pad;
    logic [PW-1:0] nb_pad;
    logic [PW-1:0] gen_bits;
    logic [PW-1:0] prop_bits;
    logic [NG:0]   group_carry;

    assign a_pad       = PW'(a);
    assign nb_pad      = ~(PW'(b));
    assign gen_bits    = a_pad & nb_pad;
    assign prop_bits   = a_pad ^ nb_pad;
    assign group_carry[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < NG; gi++) begin : g_grp
            assign group_carry[gi+1] = cla4_carry(gen_bits[4*gi +: 4],
                                                  prop_bits[4*gi +: 4],
                                                  group_carry[gi], 4);
            for (genvar bi = 0; bi < 4; bi++) begin : g_bit
                // Only the low WIDTH difference bits are ever consumed; the
                // top bit of a non-borrowing trial is always zero.
                if (4 * gi + bi < WIDTH) begin : g_sum
                    assign diff[4*gi+bi] = prop_bits[4*gi+bi]
                                         ^ cla4_carry(gen_bits[4*gi +: 4],
                                                      prop_bits[4*gi +: 4],
                                                      group_carry[gi], bi);
                end
            end
        end
    endgenerate

    assign borrow = ~group_carry[NG];

endmodule

// File: rtl/seq_divider_32.sv
// Multi-cycle restoring divider, one quotient bit per cycle. Operands are
// converted to magnitudes at Start (signed mode), divided unsigned, then the
// signs are restored in the FIX state which also registers Done.
module seq_divider_32
    import seq_divider_32_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start,
    input  logic             Signed_Op,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             Busy,
    output logic             Done,
    output logic             Div_By_Zero
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;          // partial remainder R
    logic [WIDTH-1:0]   qsh_q, qsh_d;          // dividend in, quotient out
    logic [WIDTH-1:0]   dvs_q, dvs_d;          // divisor magnitude D
    logic [WIDTH-1:0]   dvd_raw_q, dvd_raw_d;  // untouched dividend for /0
    logic               neg_quot_q, neg_quot_d;
    logic               neg_rem_q, neg_rem_d;
    logic               div0_q, div0_d;
    logic [WIDTH-1:0]   quot_q, quot_d;
    logic [WIDTH-1:0]   remo_q, remo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;

    logic               accept;
    logic               dvd_neg;
    logic               dvs_neg;
    logic [WIDTH:0]     shifted;
    logic [WIDTH-1:0]   trial_diff;
    logic               trial_borrow;

    // Start is only honoured while idle and not busy; during the Done cycle
    // Busy is still high, so a Start there waits one more cycle.
    assign accept  = Start & ~busy_q & (state_q == S_IDLE);
    assign dvd_neg = Signed_Op & Dividend[WIDTH-1];
    assign dvs_neg = Signed_Op & Divisor[WIDTH-1];

    // R shifted left with the next dividend bit. R's MSB is always zero before
    // a shift (R never exceeds the dividend prefix consumed so far), so
    // carrying it into the WIDTH+1-bit trial changes nothing.
    assign shifted = {rem_q, qsh_q[WIDTH-1]};

    sub_step_32 #(.WIDTH(WIDTH)) u_step (
        .a      (shifted),
        .b      ({1'b0, dvs_q}),
        .diff   (trial_diff),
        .borrow (trial_borrow)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: a zero divisor skips the iteration loop entirely.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = (Divisor == '0) ? S_FIX : S_RUN;
                end
            end
            S_RUN: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and output next values for each state.
    always_comb begin
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        qsh_d      = qsh_q;
        dvs_d      = dvs_q;
        dvd_raw_d  = dvd_raw_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        div0_d     = div0_q;
        quot_d     = quot_q;
        remo_d     = remo_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        dbz_d      = dbz_q;

        // Busy falls the cycle after the Done pulse.
        if (done_q) begin
            busy_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    busy_d     = 1'b1;
                    qsh_d      = dvd_neg ? -Dividend : Dividend;
                    dvs_d      = dvs_neg ? -Divisor : Divisor;
                    dvd_raw_d  = Dividend;
                    rem_d      = '0;
                    cnt_d      = CNT_W'(WIDTH);
                    neg_quot_d = dvd_neg ^ dvs_neg;
                    neg_rem_d  = dvd_neg;
                    div0_d     = (Divisor == '0);
                end
            end
            S_RUN: begin
                rem_d = trial_borrow ? shifted[WIDTH-1:0] : trial_diff;
                qsh_d = {qsh_q[WIDTH-2:0], ~trial_borrow};
                cnt_d = cnt_q - CNT_W'(1);
            end
            S_FIX: begin
                done_d = 1'b1;
                if (div0_q) begin
                    quot_d = '1;
                    remo_d = dvd_raw_q;
                    dbz_d  = 1'b1;
                end else begin
                    // -2^(W-1) / -1 wraps back to 0x8000.. through the negate.
                    quot_d = neg_quot_q ? -qsh_q : qsh_q;
                    remo_d = neg_rem_q ? -rem_q : rem_q;
                    dbz_d  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            rem_q      <= '0;
            qsh_q      <= '0;
            dvs_q      <= '0;
            dvd_raw_q  <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            div0_q     <= 1'b0;
            quot_q     <= '0;
            remo_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            qsh_q      <= qsh_d;
            dvs_q      <= dvs_d;
            dvd_raw_q  <= dvd_raw_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            div0_q     <= div0_d;
            quot_q     <= quot_d;
            remo_q     <= remo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            dbz_q      <= dbz_d;
        end
    end

    assign Quotient    = quot_q;
    assign Remainder   = remo_q;
    assign Busy        = busy_q;
    assign Done        = done_q;
    assign Div_By_Zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_32.sv
// Scoreboard bench for seq_divider_32: stimulus pushes expected results from
// an arithmetic reference model, a negedge monitor pops and compares on Done.
module tb_seq_divider_32;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         signed_op = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    seq_divider_32 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Start       (start),
        .Signed_Op   (signed_op),
        .Dividend    (dividend),
        .Divisor     (divisor),
        .Quotient    (quotient),
        .Remainder   (remainder),
        .Busy        (busy),
        .Done        (done),
        .Div_By_Zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           lat;
        int           start_cyc;
        int           id;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   done_count = 0;
    int   next_id = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer division in 64-bit arithmetic (truncating,
    // remainder follows the dividend), with the divide-by-zero convention.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        exp_t   e;
        longint sa;
        longint sd;
        e.start_cyc = 0;
        e.id = 0;
        if (b == 0) begin
            e.q = '1;
            e.r = a;
            e.dbz = 1'b1;
            e.lat = 1;
        end else begin
            e.dbz = 1'b0;
            e.lat = W + 1;
            if (s) begin
                sa = longint'($signed(a));
                sd = longint'($signed(b));
                e.q = W'(sa / sd);
                e.r = W'(sa % sd);
            end else begin
                e.q = a / b;
                e.r = a % b;
            end
        end
        return e;
    endfunction

    // Monitor: compares every Done against the oldest expectation.
    initial begin
        exp_t e;
        int   busy_run;
        bit   prev_done;
        busy_run = 0;
        prev_done = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_run = 0;
                prev_done = 0;
            end else begin
                if (prev_done) check("busy_drop", busy, 0);
                if (busy) busy_run++;
                if (done) begin
                    done_count++;
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got q=0x%0h r=0x%0h required no Done", quotient, remainder);
                    end else begin
                        e = sb.pop_front();
                        $display("op %0d: q=0x%08h r=0x%08h dbz=%0b lat=%0d busy=%0d", e.id, quotient, remainder, div_by_zero, cyc - e.start_cyc, busy_run);
                        check("quotient", quotient, e.q);
                        check("remainder", remainder, e.r);
                        check("div_by_zero", div_by_zero, e.dbz);
                        check("latency", cyc - e.start_cyc, e.lat);
                        check("busy_cycles", busy_run, e.lat + 1);
                    end
                    busy_run = 0;
                end
                prev_done = done;
            end
        end
    end

    // Drive a request (caller is at a negedge) and hold Start until accepted.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input bit push, output int acc_cyc);
        bit   pre;
        bit   ok;
        exp_t e;
        start = 1'b1;
        dividend = a;
        divisor = b;
        signed_op = s;
        ok = 0;
        acc_cyc = 0;
        for (int i = 0; i < 6 && !ok; i++) begin
            pre = busy;
            @(posedge clk);
            #1;
            if (!pre && busy) begin
                ok = 1;
                acc_cyc = cyc;
            end else begin
                @(negedge clk);
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no Busy rise required acceptance within 6 cycles");
        end else if (push) begin
            e = model(a, b, s);
            e.start_cyc = acc_cyc;
            e.id = next_id;
            next_id++;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        // Operands wander while busy; the latched copies must be used.
        dividend = $urandom;
        divisor = $urandom;
        signed_op = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy) ok = 1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got %0d pending results required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        int acc;
        @(negedge clk);
        issue(a, b, s, 1, acc);
        wait_idle();
    endtask

    initial begin
        int           acc;
        int           dc;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rs;

        repeat (3) @(negedge clk);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dbz", div_by_zero, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed cases.
        run_op(32'd100, 32'd7, 1'b0);
        run_op(-32'sd100, 32'd7, 1'b1);
        run_op(32'd100, -32'sd7, 1'b1);
        run_op(32'h0000_1234, 32'd0, 1'b0);
        run_op(32'h0000_1234, 32'd0, 1'b1);
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(32'hFFFF_FFFF, 32'h8000_0001, 1'b0);
        run_op(-32'sd100, -32'sd7, 1'b1);

        // Start pulsed mid-operation is ignored.
        @(negedge clk);
        issue(32'd1000, 32'd33, 1'b0, 1, acc);
        repeat (8) @(negedge clk);
        start = 1'b1;
        dividend = 32'd5;
        divisor = 32'd2;
        signed_op = 1'b1;
        @(negedge clk);
        start = 1'b0;

        // Start raised in the Done cycle is taken one cycle later.
        for (int i = 0; i < 100 && !done; i++) @(negedge clk);
        issue(32'hDEAD_BEEF, 32'd12345, 1'b0, 1, acc);
        wait_idle();

        // Reset in the middle of a divide aborts it.
        @(negedge clk);
        issue(32'd777, 32'd3, 1'b0, 0, acc);
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_quotient", quotient, 0);
        check("abort_remainder", remainder, 0);
        check("abort_busy", busy, 0);
        check("abort_dbz", div_by_zero, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dc = done_count;
        repeat (40) @(negedge clk);
        check("abort_no_done", done_count, dc);
        run_op(32'd777, 32'd3, 1'b0);

        // Randomized mix.
        for (int n = 0; n < 24; n++) begin
            ra = $urandom;
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0:       rb = '0;
                1, 2:    rb = W'($urandom_range(1, 100));
                3:       rb = -W'($urandom_range(1, 100));
                4:       begin ra = 32'h8000_0000; rb = $urandom; end
                default: rb = $urandom >> $urandom_range(0, 30);
            endcase
            run_op(ra, rb, rs);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion required finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
